// File: rtl/sl_pkg.sv
// Shared serial-line definitions: config field layout, word-length limits, line state enum.
package sl_pkg;

  localparam int unsigned CFG_LEN_LSB  = 0;
  localparam int unsigned CFG_LEN_W    = 6;
  localparam int unsigned CFG_FREQ_LSB = 6;
  localparam int unsigned CFG_FREQ_W   = 2;
  localparam int unsigned CFG_PAR_BIT  = 8;

  localparam logic [15:0] CFG_RST_PAR   = 16'h0120;
  localparam logic [15:0] CFG_RST_NOPAR = 16'h0020;

  localparam int unsigned WORD_LEN_MIN = 8;
  localparam int unsigned WORD_LEN_MAX = 32;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned IDX_W        = $clog2(WORD_LEN_MAX);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } sl_state_e;

  typedef struct packed {
    logic [CFG_LEN_W-1:0]  len;
    logic [CFG_FREQ_W-1:0] freq;
  } sl_cfg_t;

  // Clamp word_len to the supported range; the stored register keeps the raw value.
  function automatic sl_cfg_t decode_cfg(input logic [7:0] raw);
    sl_cfg_t             c;
    logic [CFG_LEN_W-1:0] len;
    len = raw[CFG_LEN_LSB +: CFG_LEN_W];
    if (len < CFG_LEN_W'(WORD_LEN_MIN))      c.len = CFG_LEN_W'(WORD_LEN_MIN);
    else if (len > CFG_LEN_W'(WORD_LEN_MAX)) c.len = CFG_LEN_W'(WORD_LEN_MAX);
    else                                     c.len = len;
    c.freq = raw[CFG_FREQ_LSB +: CFG_FREQ_W];
    return c;
  endfunction

endpackage

// File: rtl/sl_transmitter_if.sv
// Host-side register bus between the FIFO bridge (master) and the SL transmitter (slave).
interface sl_transmitter_if #(
  parameter int unsigned TX_CONFIG_REG_WIDTH = 16
);
  logic [31:0]                    wr_data_tx;
  logic                           data_we_tx;
  logic [TX_CONFIG_REG_WIDTH-1:0] wr_config_tx;
  logic                           config_we_tx;
  logic                           rd_status_tx;
  logic [TX_CONFIG_REG_WIDTH-1:0] rd_config_tx;
  logic                           status_changed_tx;

  modport master (
    output wr_data_tx, data_we_tx, wr_config_tx, config_we_tx,
    input  rd_status_tx, rd_config_tx, status_changed_tx
  );

  modport slave (
    input  wr_data_tx, data_we_tx, wr_config_tx, config_we_tx,
    output rd_status_tx, rd_config_tx, status_changed_tx
  );
endinterface

// File: rtl/sl_bit_timer.sv
// Bit-period divider: period BASE_DIV<<freq_sel, ticks at symbol start (cnt 0) and half-bit.
module sl_bit_timer #(
  parameter int unsigned BASE_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clear,
  input  logic [1:0] i_freq_sel,
  output logic       o_sym_tick_c,
  output logic       o_half_tick_c
);

  localparam int unsigned CNT_W = $clog2(BASE_DIV << 3);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_half;

  assign w_last = CNT_W'((BASE_DIV << i_freq_sel) - 1);
  assign w_half = CNT_W'((BASE_DIV << i_freq_sel) >> 1);

  // Held at zero while idle so every word starts on the same phase.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) r_cnt <= '0;
    else if (r_cnt == w_last) r_cnt <= '0;
    else r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_sym_tick_c  = (r_cnt == '0);
  assign o_half_tick_c = (r_cnt == w_half);

endmodule

// File: rtl/sl_transmitter.sv
// SL transmitter: config register and return-to-idle serialiser onto sl0/sl1.
// Define SL_TX_PARITY_EN to build the odd-parity symbol and config bit 8.
module sl_transmitter
  import sl_pkg::*;
#(
  parameter int unsigned BASE_DIV            = 4,
  parameter int unsigned TX_CONFIG_REG_WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  sl_transmitter_if.slave tx,
  output logic            sl0,
  output logic            sl1
);

`ifdef SL_TX_PARITY_EN
  localparam logic [TX_CONFIG_REG_WIDTH-1:0] CFG_RST  = TX_CONFIG_REG_WIDTH'(CFG_RST_PAR);
  localparam logic [TX_CONFIG_REG_WIDTH-1:0] CFG_MASK = '1;
`else
  localparam logic [TX_CONFIG_REG_WIDTH-1:0] CFG_RST  = TX_CONFIG_REG_WIDTH'(CFG_RST_NOPAR);
  localparam logic [TX_CONFIG_REG_WIDTH-1:0] CFG_MASK =
    ~(TX_CONFIG_REG_WIDTH'(1) << CFG_PAR_BIT);
`endif

  sl_state_e                      r_state;
  logic [TX_CONFIG_REG_WIDTH-1:0] r_cfg;
  logic [DATA_W-1:0]              r_shift;
  logic [IDX_W-1:0]               r_idx;
  logic [CFG_LEN_W-1:0]           r_len;
  logic [CFG_FREQ_W-1:0]          r_freq;
  logic                           r_lead;
  logic                           r_busy;
  logic                           r_chg;
  logic                           r_sl0;
  logic                           r_sl1;
`ifdef SL_TX_PARITY_EN
  logic                           r_par_en;
  logic                           r_par;
`endif

  logic [TX_CONFIG_REG_WIDTH-1:0] w_cfg_wr;
  sl_cfg_t                        w_snap;
  logic                           w_sym;
  logic                           w_half;

  assign w_cfg_wr = tx.wr_config_tx & CFG_MASK;
  // A config write in the same cycle as the start strobe applies to that word.
  assign w_snap   = decode_cfg(tx.config_we_tx ? w_cfg_wr[7:0] : r_cfg[7:0]);

  sl_bit_timer #(.BASE_DIV(BASE_DIV)) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_clear       (!r_busy),
    .i_freq_sel    (r_freq),
    .o_sym_tick_c  (w_sym),
    .o_half_tick_c (w_half)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cfg    <= CFG_RST;
      r_shift  <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_freq   <= '0;
      r_lead   <= 1'b0;
      r_busy   <= 1'b0;
      r_chg    <= 1'b0;
      r_sl0    <= 1'b1;
      r_sl1    <= 1'b1;
`ifdef SL_TX_PARITY_EN
      r_par_en <= 1'b0;
      r_par    <= 1'b0;
`endif
    end else begin
      r_chg <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (tx.config_we_tx) r_cfg <= w_cfg_wr;
          if (tx.data_we_tx) begin
            r_shift  <= tx.wr_data_tx;
            r_len    <= w_snap.len;
            r_freq   <= w_snap.freq;
            r_idx    <= '0;
            r_lead   <= 1'b1;
            r_busy   <= 1'b1;
            r_chg    <= 1'b1;
            r_state  <= ST_DATA;
`ifdef SL_TX_PARITY_EN
            r_par_en <= tx.config_we_tx ? w_cfg_wr[CFG_PAR_BIT] : r_cfg[CFG_PAR_BIT];
            r_par    <= 1'b0;
`endif
          end
        end
        // r_lead covers the one idle cycle between the start strobe and the first pulse.
        ST_DATA: begin
          if (w_sym) begin
            if (r_lead) begin
              r_lead <= 1'b0;
              r_sl0  <= r_shift[0];
              r_sl1  <= ~r_shift[0];
`ifdef SL_TX_PARITY_EN
              r_par  <= r_shift[0];
`endif
            end else if (CFG_LEN_W'(r_idx) == r_len - CFG_LEN_W'(1)) begin
`ifdef SL_TX_PARITY_EN
              if (r_par_en) begin
                r_state <= ST_PARITY;
                r_sl0   <= ~r_par;
                r_sl1   <= r_par;
              end else
`endif
              begin
                r_state <= ST_STOP;
                r_sl0   <= 1'b0;
                r_sl1   <= 1'b0;
              end
            end else begin
              r_shift <= r_shift >> 1;
              r_idx   <= r_idx + IDX_W'(1);
              r_sl0   <= r_shift[1];
              r_sl1   <= ~r_shift[1];
`ifdef SL_TX_PARITY_EN
              r_par   <= r_par ^ r_shift[1];
`endif
            end
          end else if (w_half) begin
            r_sl0 <= 1'b1;
            r_sl1 <= 1'b1;
          end
        end
`ifdef SL_TX_PARITY_EN
        ST_PARITY: begin
          if (w_sym) begin
            r_state <= ST_STOP;
            r_sl0   <= 1'b0;
            r_sl1   <= 1'b0;
          end else if (w_half) begin
            r_sl0 <= 1'b1;
            r_sl1 <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (w_sym) begin
            r_state <= ST_GAP;
            r_sl0   <= 1'b1;
            r_sl1   <= 1'b1;
          end
        end
        ST_GAP: begin
          if (w_sym) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_chg   <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_sl0   <= 1'b1;
          r_sl1   <= 1'b1;
        end
      endcase
    end
  end

  assign tx.rd_status_tx      = r_busy;
  assign tx.rd_config_tx      = r_cfg;
  assign tx.status_changed_tx = r_chg;
  assign sl0                  = r_sl0;
  assign sl1                  = r_sl1;

endmodule

// File: tb/tb_sl_transmitter.sv
// Scoreboard bench for sl_transmitter: expected symbols queued at start, popped by a line monitor.
module tb_sl_transmitter;
  localparam int unsigned BASE_DIV = 4;
  localparam int unsigned CW       = 16;
`ifdef SL_TX_PARITY_EN
  localparam bit          PAR_OK  = 1'b1;
  localparam logic [15:0] RST_CFG = 16'h0120;
`else
  localparam bit          PAR_OK  = 1'b0;
  localparam logic [15:0] RST_CFG = 16'h0020;
`endif

  typedef struct packed {
    logic [1:0] kind;   // 0: '0' bit, 1: '1' bit, 2: stop
    logic [7:0] width;
  } sym_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sl0, sl1;
  bit   mon_en = 1'b0;
  sym_t sb[$];
  logic [15:0] m_cfg;
  int n_total = 0;
  int n_bad = 0;

  sl_transmitter_if #(.TX_CONFIG_REG_WIDTH(CW)) tx_if ();

  sl_transmitter #(.BASE_DIV(BASE_DIV), .TX_CONFIG_REG_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tx    (tx_if),
    .sl0   (sl0),
    .sl1   (sl1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mask_cfg(input logic [15:0] v);
    return PAR_OK ? v : (v & ~16'h0100);
  endfunction

  // Queue the symbols of one word under m_cfg and return the expected busy length.
  function automatic int push_word(input logic [31:0] d);
    int   len, t, p, ones;
    sym_t s;
    len  = int'(m_cfg[5:0]);
    if (len < 8) len = 8;
    if (len > 32) len = 32;
    t    = BASE_DIV << m_cfg[7:6];
    p    = (PAR_OK && m_cfg[8]) ? 1 : 0;
    ones = 0;
    for (int i = 0; i < len; i++) begin
      s.kind  = {1'b0, d[i]};
      s.width = 8'(t / 2);
      sb.push_back(s);
      ones += int'(d[i]);
    end
    if (p == 1) begin
      s.kind  = (ones % 2 == 0) ? 2'd1 : 2'd0;
      s.width = 8'(t / 2);
      sb.push_back(s);
    end
    s.kind  = 2'd2;
    s.width = 8'(t);
    sb.push_back(s);
    return 1 + (len + p + 2) * t;
  endfunction

  // Line monitor: decode each low pulse and compare it with the next queued symbol.
  int         lo_cnt = 0;
  logic [1:0] lo_kind = 2'd0;
  logic       prev_busy = 1'b0;
  sym_t       mon_e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (tx_if.status_changed_tx || (tx_if.rd_status_tx !== prev_busy))
        chk("chg_edge", {31'd0, tx_if.status_changed_tx}, {31'd0, tx_if.rd_status_tx !== prev_busy});
      if (!(sl0 && sl1)) begin
        if (lo_cnt == 0) lo_kind = (!sl0 && !sl1) ? 2'd2 : (!sl0 ? 2'd0 : 2'd1);
        lo_cnt++;
      end else if (lo_cnt != 0) begin
        if (sb.size() == 0) chk("sb_extra", {30'd0, lo_kind}, 32'd3);
        else begin
          mon_e = sb.pop_front();
          chk("sym_kind", {30'd0, lo_kind}, {30'd0, mon_e.kind});
          chk("sym_width", lo_cnt, {24'd0, mon_e.width});
        end
        lo_cnt = 0;
      end
    end else begin
      lo_cnt = 0;
    end
    prev_busy = tx_if.rd_status_tx;
  end

  // Called right after a negedge; strobes land on the following rising edge.
  task automatic write_cfg(input logic [15:0] v);
    tx_if.wr_config_tx = v;
    tx_if.config_we_tx = 1'b1;
    @(negedge clk);
    tx_if.config_we_tx = 1'b0;
    m_cfg = mask_cfg(v);
    chk("cfg_rd", tx_if.rd_config_tx, m_cfg);
  endtask

  task automatic send_word(input logic [31:0] d, input bit with_cfg,
                           input logic [15:0] cfg, input bit inject);
    int exp_busy, cnt;
    bit done;
    if (with_cfg) begin
      tx_if.wr_config_tx = cfg;
      tx_if.config_we_tx = 1'b1;
      m_cfg = mask_cfg(cfg);
    end
    exp_busy = push_word(d);
    tx_if.wr_data_tx = d;
    tx_if.data_we_tx = 1'b1;
    @(negedge clk);
    tx_if.data_we_tx   = 1'b0;
    tx_if.config_we_tx = 1'b0;
    chk("busy_rise", {31'd0, tx_if.rd_status_tx}, 32'd1);
    chk("chg_rise", {31'd0, tx_if.status_changed_tx}, 32'd1);
    chk("lead_idle", {30'd0, sl1, sl0}, 32'd3);
    chk("cfg_start", tx_if.rd_config_tx, m_cfg);
    cnt  = 1;
    done = 1'b0;
    for (int g = 0; g < 2000 && !done; g++) begin
      @(negedge clk);
      if (!tx_if.rd_status_tx) done = 1'b1;
      else begin
        cnt++;
        if (cnt == 2) chk("first_sym", {30'd0, sl1, sl0}, d[0] ? 32'd1 : 32'd2);
        if (inject && cnt == 10) begin
          tx_if.wr_data_tx   = 32'hFFFF_FFFF;
          tx_if.data_we_tx   = 1'b1;
          tx_if.wr_config_tx = 16'h0000;
          tx_if.config_we_tx = 1'b1;
        end
        if (inject && cnt == 11) begin
          tx_if.data_we_tx   = 1'b0;
          tx_if.config_we_tx = 1'b0;
        end
      end
    end
    chk("busy_done", {31'd0, done}, 32'd1);
    chk("busy_len", cnt, exp_busy);
    chk("chg_fall", {31'd0, tx_if.status_changed_tx}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);
    chk("cfg_kept", tx_if.rd_config_tx, m_cfg);
  endtask

  initial begin
    tx_if.wr_data_tx   = '0;
    tx_if.data_we_tx   = 1'b0;
    tx_if.wr_config_tx = '0;
    tx_if.config_we_tx = 1'b0;
    m_cfg = RST_CFG;

    repeat (2) @(negedge clk);
    chk("rst_hold_chg", {31'd0, tx_if.status_changed_tx}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sl0", {31'd0, sl0}, 32'd1);
    chk("rst_sl1", {31'd0, sl1}, 32'd1);
    chk("rst_busy", {31'd0, tx_if.rd_status_tx}, 32'd0);
    chk("rst_cfg", tx_if.rd_config_tx, RST_CFG);
    chk("rst_chg", {31'd0, tx_if.status_changed_tx}, 32'd0);
    mon_en = 1'b1;

    write_cfg(16'h0108);
    send_word(32'h0000_00A5, 1'b0, 16'h0, 1'b0);
    send_word(32'h1234_5678, 1'b0, 16'h0, 1'b1);

    write_cfg(16'h0000);
    send_word($urandom, 1'b0, 16'h0, 1'b0);
    write_cfg(16'h0028);
    send_word($urandom, 1'b0, 16'h0, 1'b0);

    write_cfg(16'h00C8);
    send_word(32'h0000_00F0, 1'b0, 16'h0, 1'b0);

    send_word(32'h0000_01C3, 1'b1, 16'h0109, 1'b0);

    write_cfg(16'h010A);
    send_word(32'h0000_02B7, 1'b0, 16'h0, 1'b0);
    send_word(32'h0000_0148, 1'b0, 16'h0, 1'b0);

    // Abort a 32-bit word by reset while bit 3 is on the line.
    write_cfg(16'h0120);
    mon_en = 1'b0;
    tx_if.wr_data_tx = 32'h5A5A_F00F;
    tx_if.data_we_tx = 1'b1;
    @(negedge clk);
    tx_if.data_we_tx = 1'b0;
    repeat (13) @(negedge clk);
    chk("abort_busy_pre", {31'd0, tx_if.rd_status_tx}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_sl0", {31'd0, sl0}, 32'd1);
    chk("abort_sl1", {31'd0, sl1}, 32'd1);
    chk("abort_busy", {31'd0, tx_if.rd_status_tx}, 32'd0);
    chk("abort_cfg", tx_if.rd_config_tx, RST_CFG);
    chk("abort_chg", {31'd0, tx_if.status_changed_tx}, 32'd0);
    rst_n = 1'b1;
    m_cfg = RST_CFG;
    sb.delete();
    @(negedge clk);
    mon_en = 1'b1;
    send_word(32'hDEAD_BEEF, 1'b0, 16'h0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
